// File: rtl/ps2_keycode_fifo.sv
// PS/2 set-2 keyboard decoder: tracks make/break/extended prefixes, Shift and Caps Lock,
// and queues translated ASCII characters in a show-ahead FIFO.
module ps2_keycode_fifo #(
    parameter int unsigned DEPTH     = 8,
    parameter bit          REPEAT_EN = 1'b0,
    parameter bit          SHIFT_SYM = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     code_valid,
    input  logic [7:0]               code,
    input  logic                     rd_en,
    output logic [7:0]               ascii,
    output logic                     ascii_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     shift_held,
    output logic                     caps_on
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [7:0] CodeBrk    = 8'hF0;
    localparam logic [7:0] CodeExt    = 8'hE0;
    localparam logic [7:0] CodeLShift = 8'h12;
    localparam logic [7:0] CodeRShift = 8'h59;
    localparam logic [7:0] CodeCaps   = 8'h58;

    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StBrk,
        StExt,
        StExtBrk
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  held_q, held_d;
    logic        lshift_q, lshift_d;
    logic        rshift_q, rshift_d;
    logic        caps_q, caps_d;

    logic        is_make;
    logic        is_repeat;
    logic        push_req;

    logic        letter_hit;
    logic [7:0]  lower;
    logic        digit_hit;
    logic [3:0]  digit;
    logic [7:0]  sym;
    logic        xl_hit;
    logic [7:0]  xl_char;

    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q;
    logic        overflow_q;
    logic        pop;
    logic        push;

    assign shift_held = lshift_q | rshift_q;
    assign caps_on    = caps_q;

    assign is_make   = code_valid && (state_q == StIdle) && (code != CodeBrk) && (code != CodeExt);
    assign is_repeat = (code == held_q);

    // Decoder state and modifier tracking
    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        caps_d   = caps_q;
        if (code_valid) begin
            case (state_q)
                StIdle: begin
                    if (code == CodeBrk) begin
                        state_d = StBrk;
                    end else if (code == CodeExt) begin
                        state_d = StExt;
                    end else begin
                        held_d = code;
                        if (code == CodeLShift) lshift_d = 1'b1;
                        if (code == CodeRShift) rshift_d = 1'b1;
                        if (code == CodeCaps && held_q != CodeCaps) caps_d = ~caps_q;
                    end
                end
                StBrk: begin
                    state_d = StIdle;
                    if (code == CodeLShift) lshift_d = 1'b0;
                    if (code == CodeRShift) rshift_d = 1'b0;
                    if (code == held_q) held_d = 8'h00;
                end
                StExt: begin
                    state_d = (code == CodeBrk) ? StExtBrk : StIdle;
                end
                StExtBrk: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            held_q   <= 8'h00;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            caps_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            caps_q   <= caps_d;
        end
    end

    // Set-2 letter lookup, producing the lowercase form
    always_comb begin
        letter_hit = 1'b1;
        lower      = 8'h00;
        case (code)
            8'h1C: lower = 8'h61;
            8'h32: lower = 8'h62;
            8'h21: lower = 8'h63;
            8'h23: lower = 8'h64;
            8'h24: lower = 8'h65;
            8'h2B: lower = 8'h66;
            8'h34: lower = 8'h67;
            8'h33: lower = 8'h68;
            8'h43: lower = 8'h69;
            8'h3B: lower = 8'h6A;
            8'h42: lower = 8'h6B;
            8'h4B: lower = 8'h6C;
            8'h3A: lower = 8'h6D;
            8'h31: lower = 8'h6E;
            8'h44: lower = 8'h6F;
            8'h4D: lower = 8'h70;
            8'h15: lower = 8'h71;
            8'h2D: lower = 8'h72;
            8'h1B: lower = 8'h73;
            8'h2C: lower = 8'h74;
            8'h3C: lower = 8'h75;
            8'h2A: lower = 8'h76;
            8'h1D: lower = 8'h77;
            8'h22: lower = 8'h78;
            8'h35: lower = 8'h79;
            8'h1A: lower = 8'h7A;
            default: letter_hit = 1'b0;
        endcase
    end

    always_comb begin
        digit_hit = 1'b1;
        digit     = 4'd0;
        case (code)
            8'h45: digit = 4'd0;
            8'h16: digit = 4'd1;
            8'h1E: digit = 4'd2;
            8'h26: digit = 4'd3;
            8'h25: digit = 4'd4;
            8'h2E: digit = 4'd5;
            8'h36: digit = 4'd6;
            8'h3D: digit = 4'd7;
            8'h3E: digit = 4'd8;
            8'h46: digit = 4'd9;
            default: digit_hit = 1'b0;
        endcase
    end

    // US-layout shifted digit row
    always_comb begin
        case (digit)
            4'd0:    sym = 8'h29;
            4'd1:    sym = 8'h21;
            4'd2:    sym = 8'h40;
            4'd3:    sym = 8'h23;
            4'd4:    sym = 8'h24;
            4'd5:    sym = 8'h25;
            4'd6:    sym = 8'h5E;
            4'd7:    sym = 8'h26;
            4'd8:    sym = 8'h2A;
            4'd9:    sym = 8'h28;
            default: sym = 8'h00;
        endcase
    end

    // Modifiers here are the registered values, i.e. before this byte's own update
    always_comb begin
        xl_hit  = 1'b0;
        xl_char = 8'h00;
        if (letter_hit) begin
            xl_hit  = 1'b1;
            xl_char = (shift_held ^ caps_q) ? (lower - 8'h20) : lower;
        end else if (digit_hit) begin
            xl_hit  = 1'b1;
            xl_char = (shift_held && SHIFT_SYM) ? sym : (8'h30 + {4'h0, digit});
        end else begin
            case (code)
                8'h29: begin xl_hit = 1'b1; xl_char = 8'h20; end
                8'h5A: begin xl_hit = 1'b1; xl_char = 8'h0D; end
                8'h66: begin xl_hit = 1'b1; xl_char = 8'h08; end
                default: begin xl_hit = 1'b0; xl_char = 8'h00; end
            endcase
        end
    end

    assign push_req = is_make && xl_hit && (!is_repeat || REPEAT_EN);

    assign ascii_valid = (count_q != '0);
    assign full        = (count_q == FullCount);
    assign pop         = rd_en && ascii_valid;
    assign push        = push_req && (!full || pop);
    assign ascii       = ascii_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign count       = count_q;
    assign overflow    = overflow_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= xl_char;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_req && full && !pop) overflow_q <= 1'b1;
        end
    end

endmodule

// File: doc/ps2_keycode_fifo.md
Name: ps2_keycode_fifo

Overview:
- Sequential successor to the combinational scan-code-to-ASCII table.
- Consumes raw PS/2 set-2 bytes from the receiver and decodes make, break (F0) and extended (E0) prefixes.
- Tracks Shift and Caps Lock, suppresses typematic repeat, and queues translated ASCII characters in a parametrised show-ahead FIFO read by the CPU-side or display logic.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2. AW = log2(DEPTH).
- REPEAT_EN, 0, 1 means typematic repeat makes of a held key are queued; 0 means they are dropped.
- SHIFT_SYM, 1, 1 means shifted digits map to symbols; 0 means shifted digits stay digits.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- code_valid  in  1  one-cycle strobe; code holds a received byte.
- code  in  8  raw PS/2 set-2 byte.
- rd_en  in  1  pop request; ignored when empty.
- ascii  out  8  FIFO head; 8'h00 when empty.
- ascii_valid  out  1  FIFO non-empty.
- full  out  1  FIFO holds DEPTH entries.
- count  out  AW+1  current occupancy.
- overflow  out  1  sticky; set when a character is dropped because the FIFO is full.
- shift_held  out  1  left (12) or right (59) Shift currently pressed.
- caps_on  out  1  Caps Lock toggle state.

Behaviour:
- Reset: all outputs 0, FIFO empty, decoder state IDLE, held_code = 00. A reset mid-sequence (for example after F0) discards the partial sequence.
- Decoder FSM, advanced only on code_valid:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make -> IDLE.
  - BRK: any byte is a break -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is an extended make, which is ignored -> IDLE.
  - EXT_BRK: any byte is an extended break, which is ignored -> IDLE.
- Make of 12 or 59: that Shift's flag is set; nothing is queued.
- Break of 12 or 59: that Shift's flag is cleared. shift_held is the OR of the two flags.
- Make of 58: caps_on toggles, but only if held_code != 58; held_code becomes 58. Nothing is queued.
- Any make: held_code <= code.
- Break whose byte equals held_code: held_code <= 00.
- Repeat rule: a make with code == held_code (before the update) is a repeat. A repeat is queued only if REPEAT_EN = 1.
- Translation of queued makes:
  - Letters use the set-2 table (1C=A ... 1A=Z). Output is uppercase (41-5A) when shift_held XOR caps_on, else lowercase (61-7A).
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 map to 0-9 (30-39).
  - With shift_held and SHIFT_SYM = 1, digits map to ) ! @ # $ % ^ & * ( (29,21,40,23,24,25,5E,26,2A,28). Caps Lock does not affect digits.
  - 29 maps to 20, 5A to 0D, 66 to 08.
  - All other makes are unmapped and not queued.
- Shift used for translation is the value before the current byte's update.
- Latency: a byte strobed at edge N is visible on ascii and ascii_valid after edge N (one-cycle register latency). No stalling; code_valid is never back-pressured.
- FIFO is show-ahead:
  - Pop at an edge where rd_en && ascii_valid.
  - Push at an edge where a translated make is ready and either !full or a pop occurs that same edge.
  - When full with a simultaneous push and pop, both occur and count is unchanged.
  - When empty with a simultaneous push and pop, the pop is ignored and the push occurs.
  - A push attempted while full without a pop is dropped and sets overflow.
- overflow is cleared only by rst.
- Pointers are AW bits and wrap modulo DEPTH; count is exact from 0 to DEPTH.

Test Plan:
- After reset, send 1C, F0 1C -> one entry 61 ('a'), count=1. Pulse rd_en -> ascii=00, ascii_valid=0.
- Send 12, 1C, F0 1C, F0 12, 58, F0 58, 1C -> queue holds 41, 41 ('A', 'A'), caps_on=1, shift_held=0. Then 12 1C -> 61.
- Send 12, 16 with SHIFT_SYM=1 -> 21 ('!'); with SHIFT_SYM=0 -> 31. Send E0 75 and E0 F0 75 -> nothing queued, FSM back in IDLE, next 45 -> 30.
- With REPEAT_EN=0, send 1C 1C 1C F0 1C 1C -> two entries of 61. With REPEAT_EN=1 the same stimulus gives four entries.
- With DEPTH=8, queue 9 letters without reading -> full=1, count=8, overflow=1, head = first letter. Then push and pop on the same edge while full -> count stays 8 and FIFO order is preserved across pointer wrap.
- Send F0 then assert rst, then send 1C -> 61 is queued (break context discarded); overflow and caps_on are 0 after reset.
